key_fetch_seq: RTL and testbench
================================

// Module: key_fetch_seq
// PURPOSE
//  Read sequencer directly downstream of the key ROM: on request, walks ROM word addresses 0..KEY_WORDS-1,
//  drives the ROM address/chip-enable and captures each word one cycle after issue.
//  Streams the key words over a valid/ready port to the attestation HMAC key-load logic.
//  Key material leaves the block only while access_ok holds; any violation flushes the buffered key words.
// PARAMETERS
//  KEY_ADDR_MSB  4   MSB of ROM word address bus (matches ROM ADDR_MSB)
//  KEY_WORDS     10  number of 16-bit key words (ROM MEM_SIZE/2); must be <= 2**(KEY_ADDR_MSB+1)
// PORTS
//  mclk       in   1               system clock; all state on rising edge
//  puc_rst    in   1               reset, asynchronous, active-high
//  start      in   1               request a full key read; sampled in IDLE only
//  access_ok  in   1               level; high = key access permitted (SW-Att region executing)
//  busy       out  1               high from cycle after accepted start until done/abort
//  done       out  1               one-cycle pulse after last word handshake
//  abort      out  1               one-cycle pulse on access violation
//  rom_addr   out  KEY_ADDR_MSB+1  ROM word address
//  rom_cen    out  1               ROM chip enable, active low
//  rom_dout   in   16              ROM data, valid the cycle after an issue cycle
//  key_valid  out  1               output word valid
//  key_ready  in   1               consumer accepts word (handshake = valid & ready)
//  key_data   out  16              key word; forced 16'h0000 whenever key_valid=0
//  key_idx    out  KEY_ADDR_MSB+1  word index of key_data
//  key_last   out  1               key_idx == KEY_WORDS-1 (qualified by key_valid)
// BEHAVIOUR
//  Reset: FSM=IDLE, all outputs 0 except rom_cen=1; issue/out counters, inflight, buffer cleared to 0.
//  FSM IDLE -> READ: start=1 & access_ok=1. start=1 & access_ok=0 -> abort pulse next cycle, stays IDLE.
//  READ: issue cycle when issue_idx<KEY_WORDS & access_ok & (buf_cnt+inflight-pop)<2:
//   rom_cen=0, rom_addr=issue_idx (combinational from regs); issue_idx++, inflight<=1.
//  Non-issue cycles: rom_cen=1, rom_addr holds last value (never drive out-of-range address).
//  inflight=1: rom_dout pushed into 2-entry buffer at next edge with its index; pop on key_valid&key_ready.
//  Push+pop same cycle allowed; buffer never overflows (credit rule above). Full rate 1 word/cycle with ready=1.
//  Latency: start high cycle 0 -> rom_cen low cycle 1 (addr 0) -> key_valid=1, key_data=word0 cycle 3.
//  key_ready low: key_valid/key_data/key_idx stay stable; issue stalls once credits exhausted.
//  Last handshake (key_last=1) -> READ->IDLE, done=1 next cycle, busy=0 same cycle as done.
//  access_ok falls while busy (any cycle incl. same cycle as last handshake): abort=1 next cycle, buffer and
//   counters zeroed, key_valid=0, in-flight ROM word discarded, IDLE; done never asserted for that request.
//  start while busy ignored. access_ok low in IDLE: no effect. puc_rst mid-read: immediate clear, no pulses.
//  Counters are KEY_ADDR_MSB+1 bits; no wrap — issue stops at KEY_WORDS, reset to 0 on done/abort.
// STRUCTURE
//  Shared include vrased_key_defs.v: KEY_WORDS, KEY_ADDR_MSB defaults, FSM state encodings (IDLE, READ).
//  One sub-module: key_fetch_buf (2-entry data+index FIFO, sync flush, zero-on-empty output).
//  Top holds FSM, issue counter, inflight flag, credit logic, done/abort pulse regs.
// TESTING (bench pairs block with the key ROM, word i = 16'h1234*i)
//  start, ready=1, access_ok=1 -> key_valid cycles 3..12, data 0000,1234,2468,..,A3D4, key_last with idx 9,
//   done cycle 13, rom_cen low exactly 10 cycles.
//  ready toggled 1/0 each cycle -> same 10 words in order, no loss/duplicate, data stable during ready=0.
//  ready=0 throughout -> exactly 2 issues (idx 0,1), rom_cen then held high; release -> remaining 8 words follow.
//  access_ok dropped after word 4 accepted -> abort pulse next cycle, key_valid=0, key_data=0000, no done, busy=0.
//  start with access_ok=0 -> abort pulse, rom_cen never low; start while busy -> ignored, single done.
//  puc_rst asserted mid-read -> outputs immediately reset values; fresh start then yields full 10-word sequence.

Source files
------------

// File: rtl/key_fetch_seq_pkg.sv
// Shared definitions for the key ROM fetch sequencer: default geometry and FSM state encoding.
package key_fetch_seq_pkg;

    localparam int KEY_ADDR_MSB_DEF = 4;
    localparam int KEY_WORDS_DEF    = 10;
    localparam int KEY_DW           = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } fsm_state_e;

endpackage

// File: rtl/key_fetch_seq_if.sv
// Key word stream towards the HMAC key-load logic (valid/ready, data, index, last marker).
interface key_fetch_seq_if #(
    parameter int AW = 5
) ();
    logic          key_valid;
    logic          key_ready;
    logic [15:0]   key_data;
    logic [AW-1:0] key_idx;
    logic          key_last;

    modport master (output key_valid, output key_data, output key_idx, output key_last,
                    input  key_ready);
    modport slave  (input  key_valid, input  key_data, input  key_idx, input  key_last,
                    output key_ready);
endinterface

// File: rtl/key_fetch_seq_buf.sv
// Two-entry data+index FIFO between the ROM capture and the key stream; sync flush, zero-on-empty output.
module key_fetch_seq_buf
    import key_fetch_seq_pkg::*;
#(
    parameter int AW = KEY_ADDR_MSB_DEF + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [KEY_DW-1:0] push_data,
    input  logic [AW-1:0]     push_idx,
    input  logic              pop,
    output logic              out_valid,
    output logic [KEY_DW-1:0] out_data,
    output logic [AW-1:0]     out_idx,
    output logic [1:0]        cnt
);

    logic [KEY_DW-1:0] data0_q, data0_d, data1_q, data1_d;
    logic [AW-1:0]     idx0_q, idx0_d, idx1_q, idx1_d;
    logic [1:0]        cnt_q, cnt_d;

    // Slot 0 is always the head; a pop shifts slot 1 down.
    always_comb begin
        data0_d = data0_q;
        data1_d = data1_q;
        idx0_d  = idx0_q;
        idx1_d  = idx1_q;
        cnt_d   = cnt_q;
        if (flush) begin
            data0_d = '0;
            data1_d = '0;
            idx0_d  = '0;
            idx1_d  = '0;
            cnt_d   = '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        data0_d = push_data;
                        idx0_d  = push_idx;
                    end else begin
                        data1_d = push_data;
                        idx1_d  = push_idx;
                    end
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    data0_d = data1_q;
                    idx0_d  = idx1_q;
                    data1_d = '0;
                    idx1_d  = '0;
                    cnt_d   = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd2) begin
                        data0_d = data1_q;
                        idx0_d  = idx1_q;
                        data1_d = push_data;
                        idx1_d  = push_idx;
                    end else begin
                        data0_d = push_data;
                        idx0_d  = push_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data0_q <= '0;
            data1_q <= '0;
            idx0_q  <= '0;
            idx1_q  <= '0;
            cnt_q   <= '0;
        end else begin
            data0_q <= data0_d;
            data1_q <= data1_d;
            idx0_q  <= idx0_d;
            idx1_q  <= idx1_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = out_valid ? data0_q : '0;
    assign out_idx   = out_valid ? idx0_q  : '0;
    assign cnt       = cnt_q;

endmodule

// File: rtl/key_fetch_seq.sv
// Key ROM read sequencer: walks ROM words 0..KEY_WORDS-1 and streams them out while access_ok holds.
//  state   | meaning
//  ST_IDLE | waiting for start; start without access_ok pulses abort
//  ST_READ | issuing ROM reads and streaming words; access_ok loss aborts and flushes
module key_fetch_seq
    import key_fetch_seq_pkg::*;
#(
    parameter int KEY_ADDR_MSB = KEY_ADDR_MSB_DEF,
    parameter int KEY_WORDS    = KEY_WORDS_DEF
) (
    input  logic                  mclk,
    input  logic                  puc_rst,
    input  logic                  start,
    input  logic                  access_ok,
    output logic                  busy,
    output logic                  done,
    output logic                  abort,
    output logic [KEY_ADDR_MSB:0] rom_addr,
    output logic                  rom_cen,
    input  logic [KEY_DW-1:0]     rom_dout,
    key_fetch_seq_if.master       kif
);

    localparam int            AW       = KEY_ADDR_MSB + 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(KEY_WORDS - 1);
    localparam logic [AW-1:0] ONE      = AW'(1);

    fsm_state_e    state_q, state_d;
    logic [AW-1:0] issue_idx_q, issue_idx_d;
    logic          issue_end_q, issue_end_d;
    logic          inflight_q, inflight_d;
    logic [AW-1:0] inflight_idx_q, inflight_idx_d;
    logic [AW-1:0] addr_last_q, addr_last_d;
    logic          done_q, done_d;
    logic          abort_q, abort_d;

    logic              flush, pop, issue, credit_ok, last_hs, kv;
    logic              buf_valid;
    logic [KEY_DW-1:0] buf_data;
    logic [AW-1:0]     buf_idx;
    logic [1:0]        buf_cnt;
    logic [2:0]        occ;

    assign busy = (state_q == ST_READ);
    assign kv   = busy & access_ok & buf_valid;
    assign pop  = kv & kif.key_ready;

    // A word in flight already owns a buffer slot, so it counts against the two credits.
    assign occ       = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    assign credit_ok = (occ < 3'd2);
    assign issue     = busy & access_ok & ~issue_end_q & credit_ok;
    assign last_hs   = pop & (buf_idx == LAST_IDX);

    always_comb begin
        state_d        = state_q;
        issue_idx_d    = issue_idx_q;
        issue_end_d    = issue_end_q;
        inflight_d     = 1'b0;
        inflight_idx_d = inflight_idx_q;
        addr_last_d    = addr_last_q;
        done_d         = 1'b0;
        abort_d        = 1'b0;
        flush          = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (access_ok) state_d = ST_READ;
                    else           abort_d = 1'b1;
                end
            end
            ST_READ: begin
                if (!access_ok) begin
                    state_d        = ST_IDLE;
                    abort_d        = 1'b1;
                    flush          = 1'b1;
                    issue_idx_d    = '0;
                    issue_end_d    = 1'b0;
                    inflight_idx_d = '0;
                end else begin
                    if (issue) begin
                        inflight_d     = 1'b1;
                        inflight_idx_d = issue_idx_q;
                        addr_last_d    = issue_idx_q;
                        if (issue_idx_q == LAST_IDX) issue_end_d = 1'b1;
                        else                         issue_idx_d = issue_idx_q + ONE;
                    end
                    if (last_hs) begin
                        state_d     = ST_IDLE;
                        done_d      = 1'b1;
                        issue_idx_d = '0;
                        issue_end_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q        <= ST_IDLE;
            issue_idx_q    <= '0;
            issue_end_q    <= 1'b0;
            inflight_q     <= 1'b0;
            inflight_idx_q <= '0;
            addr_last_q    <= '0;
            done_q         <= 1'b0;
            abort_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            issue_idx_q    <= issue_idx_d;
            issue_end_q    <= issue_end_d;
            inflight_q     <= inflight_d;
            inflight_idx_q <= inflight_idx_d;
            addr_last_q    <= addr_last_d;
            done_q         <= done_d;
            abort_q        <= abort_d;
        end
    end

    key_fetch_seq_buf #(.AW(AW)) u_buf (
        .clk       (mclk),
        .rst       (puc_rst),
        .flush     (flush),
        .push      (inflight_q),
        .push_data (rom_dout),
        .push_idx  (inflight_idx_q),
        .pop       (pop),
        .out_valid (buf_valid),
        .out_data  (buf_data),
        .out_idx   (buf_idx),
        .cnt       (buf_cnt)
    );

    // Address holds its last issued value between issues so the ROM never sees an out-of-range word.
    assign rom_cen  = ~issue;
    assign rom_addr = issue ? issue_idx_q : addr_last_q;
    assign done     = done_q;
    assign abort    = abort_q;

    assign kif.key_valid = kv;
    assign kif.key_data  = kv ? buf_data : '0;
    assign kif.key_idx   = kv ? buf_idx  : '0;
    assign kif.key_last  = kv & (buf_idx == LAST_IDX);

endmodule

// File: tb/tb_key_fetch_seq.sv
// Bench for key_fetch_seq paired with a key ROM model (word i = 16'h1234*i).
module tb_key_fetch_seq;
    import key_fetch_seq_pkg::*;

    localparam int AW = 5;
    localparam int NW = 10;

    logic          mclk = 1'b0;
    logic          puc_rst, start, access_ok;
    logic          busy, done, abort, rom_cen;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_dout = '0;

    key_fetch_seq_if #(.AW(AW)) kif ();

    key_fetch_seq #(.KEY_ADDR_MSB(AW-1), .KEY_WORDS(NW)) dut (
        .mclk      (mclk),
        .puc_rst   (puc_rst),
        .start     (start),
        .access_ok (access_ok),
        .busy      (busy),
        .done      (done),
        .abort     (abort),
        .rom_addr  (rom_addr),
        .rom_cen   (rom_cen),
        .rom_dout  (rom_dout),
        .kif       (kif)
    );

    always #5 mclk = ~mclk;

    function automatic logic [15:0] word_of(input int i);
        return 16'(i * 32'h1234);
    endfunction

    always @(posedge mclk) if (!rom_cen) rom_dout <= word_of(int'(rom_addr));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Stream-level model: in-order delivery, ROM contents, credit bound, hold under back-pressure.
    int          exp_idx, issue_cnt, hs_cnt, done_cnt, abort_cnt;
    int          first_v_cyc, done_cyc, abort_cyc;
    logic [15:0] hs_data [NW];
    logic        prev_v, prev_r;
    logic [15:0] prev_data;
    logic [AW-1:0] prev_idx;

    task automatic model_clear();
        exp_idx = 0; issue_cnt = 0; hs_cnt = 0; done_cnt = 0; abort_cnt = 0;
        first_v_cyc = -1; done_cyc = -1; abort_cyc = -1;
        prev_v = 1'b0; prev_r = 1'b0; prev_data = '0; prev_idx = '0;
        for (int i = 0; i < NW; i++) hs_data[i] = '0;
    endtask

    always @(negedge mclk) begin
        if (puc_rst) begin
            prev_v = 1'b0;
        end else begin
            if (!kif.key_valid) begin
                chk("empty_data_zero", 32'(kif.key_data), 0);
                chk("empty_last_zero", 32'(kif.key_last), 0);
            end else begin
                chk("data_model", 32'(kif.key_data), 32'(word_of(int'(kif.key_idx))));
                chk("last_flag", 32'(kif.key_last), 32'(kif.key_idx == AW'(NW-1)));
                if (first_v_cyc < 0) first_v_cyc = cyc;
            end
            if (!access_ok) begin
                chk("valid_gated", 32'(kif.key_valid), 0);
                chk("cen_gated", 32'(rom_cen), 1);
            end
            if (prev_v && !prev_r && access_ok) begin
                chk("hold_valid", 32'(kif.key_valid), 1);
                chk("hold_data", 32'(kif.key_data), 32'(prev_data));
                chk("hold_idx", 32'(kif.key_idx), 32'(prev_idx));
            end
            if (kif.key_valid && kif.key_ready) begin
                chk("hs_order", 32'(kif.key_idx), 32'(exp_idx));
                if (exp_idx < NW) hs_data[exp_idx] = kif.key_data;
                exp_idx++;
                hs_cnt++;
            end
            if (!rom_cen) begin
                chk("issue_busy", 32'(busy), 1);
                chk("issue_addr", 32'(rom_addr), 32'(issue_cnt));
                issue_cnt++;
                chk("credit_bound", 32'(issue_cnt - hs_cnt <= 2), 1);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_all_words", 32'(hs_cnt), NW);
                chk("done_not_busy", 32'(busy), 0);
            end
            if (abort) begin
                abort_cnt++;
                abort_cyc = cyc;
                chk("abort_not_busy", 32'(busy), 0);
                chk("abort_no_valid", 32'(kif.key_valid), 0);
            end
            prev_v    = kif.key_valid;
            prev_r    = kif.key_ready;
            prev_data = kif.key_data;
            prev_idx  = kif.key_idx;
        end
    end

    task automatic step();
        @(posedge mclk);
        #2;
    endtask

    task automatic pulse_start(output int s);
        start = 1'b1;
        s = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        if (done_cnt == 0) chk("done_timeout", 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, d, n;
        puc_rst = 1'b1; start = 1'b0; access_ok = 1'b1; kif.key_ready = 1'b0;
        model_clear();
        step(); step();
        chk("rst_rom_cen", 32'(rom_cen), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_abort", 32'(abort), 0);
        chk("rst_valid", 32'(kif.key_valid), 0);
        chk("rst_data", 32'(kif.key_data), 0);
        chk("rst_addr", 32'(rom_addr), 0);
        puc_rst = 1'b0;
        step();

        // Full-rate read
        model_clear();
        kif.key_ready = 1'b1;
        pulse_start(s);
        chk("t1_busy_c1", 32'(busy), 1);
        chk("t1_cen_c1", 32'(rom_cen), 0);
        chk("t1_addr_c1", 32'(rom_addr), 0);
        wait_done(40);
        chk("t1_first_valid_cyc", 32'(first_v_cyc - s), 3);
        chk("t1_done_cyc", 32'(done_cyc - s), 13);
        chk("t1_cen_low_cycles", 32'(issue_cnt), 10);
        chk("t1_words", 32'(hs_cnt), 10);
        chk("t1_word1", 32'(hs_data[1]), 32'h1234);
        chk("t1_word9", 32'(hs_data[9]), 32'hA3D4);
        chk("t1_no_abort", 32'(abort_cnt), 0);

        // Ready toggling every cycle
        model_clear();
        kif.key_ready = 1'b1;
        pulse_start(s);
        n = 0;
        while (done_cnt == 0 && n < 60) begin
            kif.key_ready = ~kif.key_ready;
            step();
            n++;
        end
        if (done_cnt == 0) chk("t2_done_timeout", 0, 1);
        chk("t2_words", 32'(hs_cnt), 10);
        chk("t2_word5", 32'(hs_data[5]), 32'h5B04);
        chk("t2_single_done", 32'(done_cnt), 1);

        // Consumer stalled throughout, then released
        model_clear();
        kif.key_ready = 1'b0;
        pulse_start(s);
        repeat (20) step();
        chk("t3_two_issues", 32'(issue_cnt), 2);
        chk("t3_cen_high", 32'(rom_cen), 1);
        chk("t3_valid", 32'(kif.key_valid), 1);
        chk("t3_idx0", 32'(kif.key_idx), 0);
        chk("t3_data0", 32'(kif.key_data), 0);
        kif.key_ready = 1'b1;
        wait_done(40);
        chk("t3_words", 32'(hs_cnt), 10);
        chk("t3_issues", 32'(issue_cnt), 10);

        // access_ok dropped after word 4 accepted
        model_clear();
        kif.key_ready = 1'b1;
        pulse_start(s);
        n = 0;
        while (hs_cnt < 5 && n < 40) begin
            step();
            n++;
        end
        if (hs_cnt < 5) chk("t4_hs_timeout", 0, 1);
        access_ok = 1'b0;
        d = cyc;
        step();
        chk("t4_abort_pulse", 32'(abort), 1);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_valid", 32'(kif.key_valid), 0);
        chk("t4_data", 32'(kif.key_data), 0);
        step();
        chk("t4_abort_one_cycle", 32'(abort), 0);
        chk("t4_abort_cyc", 32'(abort_cyc - d), 1);
        access_ok = 1'b1;
        repeat (5) step();
        chk("t4_words", 32'(hs_cnt), 5);
        chk("t4_no_done", 32'(done_cnt), 0);
        chk("t4_abort_cnt", 32'(abort_cnt), 1);
        chk("t4_idle_cen", 32'(rom_cen), 1);
        chk("t4_idle_busy", 32'(busy), 0);

        // Start refused without access
        model_clear();
        access_ok = 1'b0;
        pulse_start(s);
        chk("t5_abort_pulse", 32'(abort), 1);
        chk("t5_busy", 32'(busy), 0);
        step();
        chk("t5_abort_cnt", 32'(abort_cnt), 1);
        chk("t5_no_issue", 32'(issue_cnt), 0);
        access_ok = 1'b1;
        step();

        // Start while busy is ignored
        model_clear();
        kif.key_ready = 1'b1;
        pulse_start(s);
        repeat (3) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(40);
        repeat (10) step();
        chk("t5_single_done", 32'(done_cnt), 1);
        chk("t5_words", 32'(hs_cnt), 10);
        chk("t5_issues", 32'(issue_cnt), 10);

        // Reset mid-read, then fresh read
        model_clear();
        pulse_start(s);
        repeat (5) step();
        puc_rst = 1'b1;
        #1;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_cen", 32'(rom_cen), 1);
        chk("t6_valid", 32'(kif.key_valid), 0);
        chk("t6_data", 32'(kif.key_data), 0);
        chk("t6_done", 32'(done), 0);
        chk("t6_abort", 32'(abort), 0);
        chk("t6_addr", 32'(rom_addr), 0);
        step(); step();
        puc_rst = 1'b0;
        model_clear();
        pulse_start(s);
        wait_done(40);
        chk("t6_words", 32'(hs_cnt), 10);
        chk("t6_issues", 32'(issue_cnt), 10);
        chk("t6_no_abort", 32'(abort_cnt), 0);
        chk("t6_done_cyc", 32'(done_cyc - s), 13);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
